// File: rtl/array_9_fifo.sv
// 32x4 ready/valid FIFO controller driving one array_9_ext single-port SRAM, with a 2-entry output buffer.
// Optional RAM bypass when the FIFO is drained: define ARRAY_9_FIFO_BYPASS_EN.
module array_9_fifo (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enq_valid,
    output logic       enq_ready,
    input  logic [3:0] enq_bits,
    output logic       deq_valid,
    input  logic       deq_ready,
    output logic [3:0] deq_bits,
    output logic [4:0] mem_addr,
    output logic       mem_en,
    output logic       mem_wmode,
    output logic [3:0] mem_wmask,
    output logic [3:0] mem_wdata,
    input  logic [3:0] mem_rdata,
    output logic [5:0] count
);

    logic [4:0] r_wrPtr;
    logic [4:0] r_rdPtr;
    logic [5:0] r_ramCnt;
    logic       r_inflight;
    logic [1:0] r_bufCnt;
    logic [3:0] r_buf0;
    logic [3:0] r_buf1;

    logic       w_rdIssue;
    logic       w_bypassOk;
    logic       w_enqFire;
    logic       w_ramWrite;
    logic       w_bypassFire;
    logic       w_push;
    logic       w_pop;
    logic [3:0] w_pushData;
    logic [1:0] w_bufCntNext;
    logic [3:0] w_buf0Next;
    logic [3:0] w_buf1Next;

    // A read is only launched when the buffer is guaranteed a free slot on its return.
    assign w_rdIssue = (r_ramCnt != 6'd0) &&
                       (({1'b0, r_bufCnt} + {2'b00, r_inflight}) < 3'd2);

`ifdef ARRAY_9_FIFO_BYPASS_EN
    assign w_bypassOk = (r_ramCnt == 6'd0) && !r_inflight && (r_bufCnt < 2'd2);
`else
    assign w_bypassOk = 1'b0;
`endif

    assign enq_ready    = !w_rdIssue && ((r_ramCnt < 6'd32) || w_bypassOk);
    assign w_enqFire    = enq_valid && enq_ready;
    assign w_bypassFire = w_enqFire && w_bypassOk;
    assign w_ramWrite   = w_enqFire && !w_bypassOk;

    assign mem_en    = w_rdIssue || w_ramWrite;
    assign mem_wmode = !w_rdIssue && w_ramWrite;
    assign mem_addr  = w_rdIssue ? r_rdPtr : r_wrPtr;
    assign mem_wmask = 4'hF;
    assign mem_wdata = enq_bits;

    // Return and bypass can never coincide: bypass requires no read in flight.
    assign w_push     = r_inflight || w_bypassFire;
    assign w_pushData = r_inflight ? mem_rdata : enq_bits;
    assign w_pop      = deq_ready && (r_bufCnt != 2'd0);

    assign deq_valid = (r_bufCnt != 2'd0);
    assign deq_bits  = r_buf0;
    assign count     = r_ramCnt + {5'b00000, r_inflight} + {4'b0000, r_bufCnt};

    always_comb begin
        w_bufCntNext = r_bufCnt;
        w_buf0Next   = r_buf0;
        w_buf1Next   = r_buf1;
        case ({w_push, w_pop})
            2'b10: begin
                if (r_bufCnt == 2'd0) begin
                    w_buf0Next = w_pushData;
                end else begin
                    w_buf1Next = w_pushData;
                end
                w_bufCntNext = r_bufCnt + 2'd1;
            end
            2'b01: begin
                w_buf0Next   = r_buf1;
                w_bufCntNext = r_bufCnt - 2'd1;
            end
            2'b11: begin
                if (r_bufCnt == 2'd1) begin
                    w_buf0Next = w_pushData;
                end else begin
                    w_buf0Next = r_buf1;
                    w_buf1Next = w_pushData;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wrPtr    <= 5'd0;
            r_rdPtr    <= 5'd0;
            r_ramCnt   <= 6'd0;
            r_inflight <= 1'b0;
            r_bufCnt   <= 2'd0;
            r_buf0     <= 4'h0;
            r_buf1     <= 4'h0;
        end else begin
            r_inflight <= w_rdIssue;
            r_bufCnt   <= w_bufCntNext;
            r_buf0     <= w_buf0Next;
            r_buf1     <= w_buf1Next;
            if (w_rdIssue) begin
                r_rdPtr  <= r_rdPtr + 5'd1;
                r_ramCnt <= r_ramCnt - 6'd1;
            end else if (w_ramWrite) begin
                r_wrPtr  <= r_wrPtr + 5'd1;
                r_ramCnt <= r_ramCnt + 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_array_9_fifo.sv
// Scoreboard bench for array_9_fifo with a behavioural 32x4 SRAM (1-cycle registered read).
module tb_array_9_fifo;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       enq_valid = 1'b0;
    logic       enq_ready;
    logic [3:0] enq_bits = 4'h0;
    logic       deq_valid;
    logic       deq_ready = 1'b0;
    logic [3:0] deq_bits;
    logic [4:0] mem_addr;
    logic       mem_en;
    logic       mem_wmode;
    logic [3:0] mem_wmask;
    logic [3:0] mem_wdata;
    logic [3:0] mem_rdata = 4'h0;
    logic [5:0] count;

    logic [3:0] ram [32];
    logic [3:0] sbQueue [$];
    int         assertCount = 0;
    int         failCount = 0;
    int         modelCount = 0;
    logic [4:0] expWr = 5'd0;
    logic [4:0] expRd = 5'd0;
    int         wrWraps = 0;
    int         rdWraps = 0;
    logic       readCycle;
    logic       writeCycle;
    logic [3:0] expHead;

    array_9_fifo dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_bits  (enq_bits),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .deq_bits  (deq_bits),
        .mem_addr  (mem_addr),
        .mem_en    (mem_en),
        .mem_wmode (mem_wmode),
        .mem_wmask (mem_wmask),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .count     (count)
    );

    always #5 clock = ~clock;

    // Behavioural stand-in for the array_9_ext macro.
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_wmode) begin
                ram[mem_addr] <= mem_wdata;
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every deq fire and checks port-level invariants.
    always @(negedge clock) begin
        if (!reset_n) begin
            modelCount = 0;
            expWr = 5'd0;
            expRd = 5'd0;
        end else begin
            readCycle  = mem_en && !mem_wmode;
            writeCycle = mem_en && mem_wmode;
            checkOutput("count", 8'(count), 8'(modelCount));
            checkOutput("wmask", 8'(mem_wmask), 8'h0F);
            checkOutput("enqReadyRule", 8'(enq_ready), 8'(!readCycle && (modelCount < 34)));
            if (modelCount == 0) checkOutput("emptyDeqValid", 8'(deq_valid), 8'h00);
            if (readCycle) begin
                checkOutput("rdAddr", 8'(mem_addr), 8'(expRd));
                if (expRd == 5'd31) rdWraps++;
                expRd = expRd + 5'd1;
            end
            if (writeCycle) begin
                checkOutput("wrAddr", 8'(mem_addr), 8'(expWr));
                checkOutput("wrData", 8'(mem_wdata), 8'(enq_bits));
                checkOutput("wrOnFire", 8'(enq_valid && enq_ready), 8'h01);
                if (expWr == 5'd31) wrWraps++;
                expWr = expWr + 5'd1;
            end
            if (deq_valid && deq_ready) begin
                if (sbQueue.size() == 0) begin
                    assertCount++;
                    failCount++;
                    $display("[TB] FAIL deqUnderflow: got deq_bits %0h, expected no output at %0t", deq_bits, $time);
                end else begin
                    expHead = sbQueue.pop_front();
                    checkOutput("deqOrder", 8'(deq_bits), 8'(expHead));
                end
                modelCount--;
            end
            if (enq_valid && enq_ready) modelCount++;
        end
    end

    task automatic applyStimulus(input logic v, input logic [3:0] d, input logic r, output logic fired);
        enq_valid = v;
        enq_bits  = d;
        deq_ready = r;
        @(negedge clock);
        fired = v && enq_ready;
        if (fired) sbQueue.push_back(d);
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input string name);
        int   n;
        logic f;
        n = 0;
        while (sbQueue.size() != 0 && n < 400) begin
            applyStimulus(1'b0, 4'h0, 1'b1, f);
            nextCycle();
            n++;
        end
        checkOutput({name, "Drained"}, 8'(sbQueue.size()), 8'h00);
        applyStimulus(1'b0, 4'h0, 1'b0, f);
        checkOutput({name, "CountZero"}, 8'(count), 8'h00);
        checkOutput({name, "DeqValidLow"}, 8'(deq_valid), 8'h00);
        nextCycle();
    endtask

    task automatic fillToFull();
        int   i;
        int   n;
        logic f;
        i = 0;
        n = 0;
        while (i < 34 && n < 300) begin
            applyStimulus(1'b1, i[3:0], 1'b0, f);
            nextCycle();
            if (f) i++;
            n++;
        end
        checkOutput("fillAccepted", 8'(i), 8'd34);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 4'hF, 1'b0, f);
            checkOutput("fullEnqReady", 8'(enq_ready), 8'h00);
            checkOutput("fullCount", 8'(count), 8'd34);
            nextCycle();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic f;
        int   pushed;
        int   n;

        repeat (2) @(posedge clock);
        #1;
        checkOutput("resetCount", 8'(count), 8'h00);
        checkOutput("resetDeqValid", 8'(deq_valid), 8'h00);
        checkOutput("resetEnqReady", 8'(enq_ready), 8'h01);
        checkOutput("resetMemEn", 8'(mem_en), 8'h00);
        #2 reset_n = 1'b1;
        nextCycle();
        applyStimulus(1'b0, 4'h0, 1'b0, f);
        checkOutput("idleCount", 8'(count), 8'h00);
        checkOutput("idleDeqValid", 8'(deq_valid), 8'h00);
        checkOutput("idleEnqReady", 8'(enq_ready), 8'h01);
        checkOutput("idleMemEn", 8'(mem_en), 8'h00);
        nextCycle();

`ifdef ARRAY_9_FIFO_BYPASS_EN
        applyStimulus(1'b1, 4'h5, 1'b0, f);
        checkOutput("bypassC0Accept", 8'(f), 8'h01);
        checkOutput("bypassC0MemEn", 8'(mem_en), 8'h00);
        nextCycle();
        applyStimulus(1'b0, 4'h0, 1'b0, f);
        checkOutput("bypassC1MemEn", 8'(mem_en), 8'h00);
        checkOutput("bypassC1DeqValid", 8'(deq_valid), 8'h01);
        checkOutput("bypassC1DeqBits", 8'(deq_bits), 8'h05);
        nextCycle();
        drain("bypass");
`else
        applyStimulus(1'b1, 4'hA, 1'b0, f);
        checkOutput("ramC0Accept", 8'(f), 8'h01);
        checkOutput("ramC0MemEn", 8'(mem_en), 8'h01);
        checkOutput("ramC0Wmode", 8'(mem_wmode), 8'h01);
        checkOutput("ramC0Addr", 8'(mem_addr), 8'h00);
        checkOutput("ramC0Wdata", 8'(mem_wdata), 8'h0A);
        nextCycle();
        applyStimulus(1'b0, 4'h0, 1'b0, f);
        checkOutput("ramC1MemEn", 8'(mem_en), 8'h01);
        checkOutput("ramC1Wmode", 8'(mem_wmode), 8'h00);
        checkOutput("ramC1Addr", 8'(mem_addr), 8'h00);
        checkOutput("ramC1DeqValid", 8'(deq_valid), 8'h00);
        nextCycle();
        applyStimulus(1'b0, 4'h0, 1'b0, f);
        checkOutput("ramC2DeqValid", 8'(deq_valid), 8'h00);
        nextCycle();
        applyStimulus(1'b0, 4'h0, 1'b0, f);
        checkOutput("ramC3DeqValid", 8'(deq_valid), 8'h01);
        checkOutput("ramC3DeqBits", 8'(deq_bits), 8'h0A);
        nextCycle();
        drain("ramPath");
`endif

        fillToFull();
        drain("fill");

        // Hold five entries, then pull reset in the middle of a cycle.
        pushed = 0;
        n = 0;
        while (pushed < 5 && n < 50) begin
            applyStimulus(1'b1, 4'(pushed + 1), 1'b0, f);
            nextCycle();
            if (f) pushed++;
            n++;
        end
        checkOutput("midAccepted", 8'(pushed), 8'd5);
        applyStimulus(1'b0, 4'h0, 1'b0, f);
        nextCycle();
        #2 reset_n = 1'b0;
        #1;
        checkOutput("midResetCount", 8'(count), 8'h00);
        checkOutput("midResetDeqValid", 8'(deq_valid), 8'h00);
        checkOutput("midResetEnqReady", 8'(enq_ready), 8'h01);
        checkOutput("midResetMemEn", 8'(mem_en), 8'h00);
        sbQueue.delete();
        @(posedge clock);
        #3 reset_n = 1'b1;
        nextCycle();

        pushed = 0;
        n = 0;
        while (pushed < 100 && n < 3000) begin
            applyStimulus(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)), f);
            nextCycle();
            if (f) pushed++;
            n++;
        end
        checkOutput("randomAccepted", 8'(pushed), 8'd100);
        drain("random");

        fillToFull();
        drain("refill");

        checkOutput("wrPtrWraps", 8'(wrWraps >= 3), 8'h01);
        checkOutput("rdPtrWraps", 8'(rdWraps >= 3), 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
